// File: rtl/halfband_pkg.sv
// Shared definitions for the halfband decimator: widths, the halfband
// coefficient set, rounding constants and the MAC sequencer states.
package halfband_pkg;

   localparam int bw   = 16;
   localparam int cw   = 16;
   localparam int aw   = bw + cw + 2;
   localparam int TAPS = 15;

   // Symmetric halfband taps, DC gain 32768; odd taps other than the centre are zero
   localparam logic signed [cw-1:0] H0 = -16'sd120;
   localparam logic signed [cw-1:0] H2 = 16'sd700;
   localparam logic signed [cw-1:0] H4 = -16'sd2300;
   localparam logic signed [cw-1:0] H6 = 16'sd9912;
   localparam logic signed [cw-1:0] H7 = 16'sd16384;

   localparam logic signed [aw-1:0] ROUND_CONST = 34'sd16384;
   localparam int                   SHIFT       = 15;
   localparam logic signed [aw-1:0] SAT_MAX     = 34'sd32767;
   localparam logic signed [aw-1:0] SAT_MIN     = -34'sd32768;

   localparam logic [2:0] TAP_PAIR0  = 3'd0;
   localparam logic [2:0] TAP_PAIR1  = 3'd1;
   localparam logic [2:0] TAP_PAIR2  = 3'd2;
   localparam logic [2:0] TAP_PAIR3  = 3'd3;
   localparam logic [2:0] TAP_CENTER = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      PAIR0,
      PAIR1,
      PAIR2,
      PAIR3,
      CENTER,
      ROUND
   } state_t;

   // Coefficient for a tap-select: pairs 0..3 map to h0,h2,h4,h6, anything else is the centre tap
   function automatic logic signed [cw-1:0] tapCoef(input logic [2:0] tapSel);
      case (tapSel)
         TAP_PAIR0: return H0;
         TAP_PAIR1: return H2;
         TAP_PAIR2: return H4;
         TAP_PAIR3: return H6;
         default:   return H7;
      endcase
   endfunction

endpackage

// File: rtl/halfband_decim_if.sv
// Sample-stream bundle between the CIC stage and the halfband decimator.
// Optional bypass control appears when HALFBAND_DECIM_BYPASS_EN is defined.
interface halfband_decim_if;
   import halfband_pkg::*;

   logic                 enable;
   logic                 strobe_in;
   logic signed [bw-1:0] signal_in;
   logic                 strobe_out;
   logic signed [bw-1:0] signal_out;
   logic                 overrun;
`ifdef HALFBAND_DECIM_BYPASS_EN
   logic                 bypass;

   modport master (
      output enable, strobe_in, signal_in, bypass,
      input  strobe_out, signal_out, overrun
   );

   modport slave (
      input  enable, strobe_in, signal_in, bypass,
      output strobe_out, signal_out, overrun
   );
`else
   modport master (
      output enable, strobe_in, signal_in,
      input  strobe_out, signal_out, overrun
   );

   modport slave (
      input  enable, strobe_in, signal_in,
      output strobe_out, signal_out, overrun
   );
`endif

endinterface

// File: rtl/hb_mac.sv
// Serial multiply-accumulate for the halfband filter: symmetric pre-add,
// signed coefficient multiply, accumulate, then round/saturate to sample width.
module hb_mac
   import halfband_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic                 accum_i,
   input  logic                 round_i,
   input  logic [2:0]           tapSel_i,
   input  logic signed [bw-1:0] opA_i,
   input  logic signed [bw-1:0] opB_i,
   output logic signed [bw-1:0] result_o
);

   logic signed [bw:0]   preAdd;
   logic signed [cw-1:0] coef;
   logic signed [aw-1:0] preAddExt;
   logic signed [aw-1:0] coefExt;
   logic signed [aw-1:0] product;
   logic signed [aw-1:0] rounded;
   logic signed [aw-1:0] shifted;
   logic signed [bw-1:0] satVal;
   logic signed [aw-1:0] acc_q, acc_d;
   logic signed [bw-1:0] result_q, result_d;

   // Arithmetic path: pre-add the symmetric pair, scale by the tap, and form the rounded output
   always_comb begin
      coef      = tapCoef(tapSel_i);
      preAdd    = {opA_i[bw-1], opA_i} + {opB_i[bw-1], opB_i};
      preAddExt = {{(aw-bw-1){preAdd[bw]}}, preAdd};
      coefExt   = {{(aw-cw){coef[cw-1]}}, coef};
      product   = preAddExt * coefExt;
      rounded   = acc_q + ROUND_CONST;
      shifted   = rounded >>> SHIFT;
      if (shifted > SAT_MAX) begin
         satVal = SAT_MAX[bw-1:0];
      end else if (shifted < SAT_MIN) begin
         satVal = SAT_MIN[bw-1:0];
      end else begin
         satVal = shifted[bw-1:0];
      end
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (accum_i) begin
         acc_d = acc_q + product;
      end
      result_d = result_q;
      if (round_i) begin
         result_d = satVal;
      end
   end

   // Accumulator and rounded-result registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: rtl/halfband_decim.sv
// Halfband decimate-by-2 stage after the CIC: 15-tap FIR computed by one
// serial MAC over 7 clocks, one output per two accepted inputs.
// Optional macro HALFBAND_DECIM_BYPASS_EN adds a bypass control that passes
// each accepted input straight to the output one clock later.
module halfband_decim
   import halfband_pkg::*;
(
   input logic            clock,
   input logic            reset,
   halfband_decim_if.slave bus
);

   state_t               state_q, state_d;
   logic signed [bw-1:0] x_q [0:TAPS-1];
   logic                 phase_q, phase_d;
   logic                 overrun_q, overrun_d;
   logic                 pending_q, pending_d;
   logic                 outStrobe_q, outStrobe_d;
   logic signed [bw-1:0] outData_q, outData_d;

   logic                 bypassSel;
   logic                 accept;
   logic                 startMac;
   logic                 busyDrop;
   logic                 macClear;
   logic                 macAccum;
   logic                 macRound;
   logic [2:0]           tapSel;
   logic signed [bw-1:0] opA;
   logic signed [bw-1:0] opB;
   logic signed [bw-1:0] macResult;

`ifdef HALFBAND_DECIM_BYPASS_EN
   assign bypassSel = bus.bypass;
`else
   assign bypassSel = 1'b0;
`endif

   assign accept   = bus.strobe_in && bus.enable && (state_q == IDLE);
   assign startMac = accept && phase_q && !bypassSel;
   assign busyDrop = bus.strobe_in && bus.enable && (state_q != IDLE);

   // Sequencer: walk the four symmetric pairs, the centre tap, then round
   always_comb begin
      state_d  = state_q;
      macClear = 1'b0;
      macAccum = 1'b0;
      macRound = 1'b0;
      tapSel   = TAP_PAIR0;
      opA      = '0;
      opB      = '0;
      case (state_q)
         IDLE: begin
            if (startMac) begin
               state_d  = PAIR0;
               macClear = 1'b1;
            end
         end
         PAIR0: begin
            tapSel   = TAP_PAIR0;
            opA      = x_q[0];
            opB      = x_q[14];
            macAccum = 1'b1;
            state_d  = PAIR1;
         end
         PAIR1: begin
            tapSel   = TAP_PAIR1;
            opA      = x_q[2];
            opB      = x_q[12];
            macAccum = 1'b1;
            state_d  = PAIR2;
         end
         PAIR2: begin
            tapSel   = TAP_PAIR2;
            opA      = x_q[4];
            opB      = x_q[10];
            macAccum = 1'b1;
            state_d  = PAIR3;
         end
         PAIR3: begin
            tapSel   = TAP_PAIR3;
            opA      = x_q[6];
            opB      = x_q[8];
            macAccum = 1'b1;
            state_d  = CENTER;
         end
         CENTER: begin
            tapSel   = TAP_CENTER;
            opA      = x_q[7];
            macAccum = 1'b1;
            state_d  = ROUND;
         end
         ROUND: begin
            macRound = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!bus.enable) begin
         state_d  = IDLE;
         macClear = 1'b0;
         macAccum = 1'b0;
         macRound = 1'b0;
      end
   end

   // Control and output next-state: phase, sticky overrun, and the output strobe one clock after ROUND
   always_comb begin
      phase_d     = phase_q;
      overrun_d   = overrun_q | busyDrop;
      pending_d   = (state_q == ROUND) && bus.enable;
      outStrobe_d = 1'b0;
      outData_d   = outData_q;
      if (!bus.enable) begin
         phase_d = 1'b0;
      end else if (accept) begin
         phase_d = bypassSel ? 1'b0 : ~phase_q;
      end
      if (pending_q && bus.enable) begin
         outStrobe_d = 1'b1;
         outData_d   = macResult;
      end
      if (accept && bypassSel) begin
         outStrobe_d = 1'b1;
         outData_d   = bus.signal_in;
      end
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         overrun_q   <= 1'b0;
         pending_q   <= 1'b0;
         outStrobe_q <= 1'b0;
         outData_q   <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         overrun_q   <= overrun_d;
         pending_q   <= pending_d;
         outStrobe_q <= outStrobe_d;
         outData_q   <= outData_d;
      end
   end

   // Sample delay line: newest sample enters x[0] only when an input is accepted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < TAPS; j++) begin
            x_q[j] <= '0;
         end
      end else if (accept) begin
         for (int j = TAPS - 1; j > 0; j--) begin
            x_q[j] <= x_q[j-1];
         end
         x_q[0] <= bus.signal_in;
      end
   end

   hb_mac mac (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (macClear),
      .accum_i  (macAccum),
      .round_i  (macRound),
      .tapSel_i (tapSel),
      .opA_i    (opA),
      .opB_i    (opB),
      .result_o (macResult)
   );

   assign bus.strobe_out = outStrobe_q;
   assign bus.signal_out = outData_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_halfband_decim.sv
// Scoreboard bench for halfband_decim: stimulus pushes expected outputs
// (hand tables or a direct-form reference FIR), a monitor pops on strobe_out.
module tb_halfband_decim;
   import halfband_pkg::*;

   typedef struct {
      int     value;
      longint cyc;
   } exp_t;

   logic clock;
   logic reset;

   halfband_decim_if bus();

   halfband_decim dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t   expQ[$];
   exp_t   monE;
   int     total = 0;
   int     bad = 0;
   longint cyc = 0;
   int     strobeCount = 0;
   int     sc0 = 0;
   int     hist[15];
   int     phase = 0;
   int     coef[15] = '{-120, 0, 700, 0, -2300, 0, 9912, 16384, 9912, 0, -2300, 0, 700, 0, -120};
   int     tblA[8] = '{0, 0, 0, 8192, 0, 0, 0, 0};
   int     tblB[9] = '{-60, 350, -1150, 4956, 4956, -1150, 350, -60, 0};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

`ifdef HALFBAND_DECIM_BYPASS_EN
   initial bus.bypass = 1'b0;
`endif

   task automatic checkOutput(input string name, input longint actual, input longint required);
      total++;
      if (actual != required) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   function automatic int refOut();
      longint acc = 0;
      for (int i = 0; i < 15; i++) begin
         acc += longint'(hist[i]) * longint'(coef[i]);
      end
      acc = (acc + 16384) >>> 15;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   function automatic void modelShift(input int sample);
      for (int i = 14; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sample;
   endfunction

   function automatic void modelClear();
      for (int i = 0; i < 15; i++) hist[i] = 0;
      phase = 0;
   endfunction

   // One accepted input, 8 clocks per call; pushes an expectation on output phases
   task automatic applyStimulus(input int sample, input bit useHand, input int handVal);
      exp_t e;
      @(negedge clock);
      bus.signal_in = 16'(sample);
      bus.strobe_in = 1'b1;
      modelShift(sample);
      if (phase == 1) begin
         e.value = useHand ? handVal : refOut();
         e.cyc   = cyc + 8;
         expQ.push_back(e);
      end
      phase = 1 - phase;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   // Monitor: every strobe_out must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (bus.strobe_out === 1'b1) begin
         strobeCount++;
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_strobe actual=%0d required=no_output", bus.signal_out);
         end else begin
            monE = expQ.pop_front();
            checkOutput("out_value", longint'(bus.signal_out), longint'(monE.value));
            checkOutput("out_cycle", cyc, monE.cyc);
         end
      end
   end

   initial begin
      modelClear();
      bus.enable    = 1'b1;
      bus.strobe_in = 1'b0;
      bus.signal_in = '0;
      reset         = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_strobe_out", bus.strobe_out, 0);
      checkOutput("rst_signal_out", bus.signal_out, 0);
      checkOutput("rst_overrun", bus.overrun, 0);

      $display("[TB] impulse as first input");
      for (int i = 0; i < 16; i++) begin
         applyStimulus((i == 0) ? 16384 : 0, 1'b1, tblA[i/2]);
      end

      $display("[TB] impulse as second input");
      for (int i = 0; i < 18; i++) begin
         applyStimulus((i == 1) ? 16384 : 0, 1'b1, tblB[i/2]);
      end

      $display("[TB] constant 1000");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1000, i >= 15, 1000);
      end

      $display("[TB] full-scale step");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(32767, i == 15, 32767);
      end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(-32768, i == 15, -32768);
      end
      repeat (3) @(negedge clock);
      checkOutput("hold_signal_out", longint'(bus.signal_out), -32768);

      $display("[TB] overrun");
      applyStimulus(2500, 1'b0, 0);
      @(negedge clock);
      bus.signal_in = 16'(-4000);
      bus.strobe_in = 1'b1;
      modelShift(-4000);
      monE.value = refOut();
      monE.cyc   = cyc + 8;
      expQ.push_back(monE);
      phase = 0;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      repeat (3) @(negedge clock);
      bus.signal_in = 16'(12345);
      bus.strobe_in = 1'b1;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      repeat (4) @(negedge clock);
      checkOutput("overrun_set", bus.overrun, 1);
      applyStimulus(3000, 1'b0, 0);
      applyStimulus(-1500, 1'b0, 0);
      checkOutput("overrun_sticky", bus.overrun, 1);

      $display("[TB] enable drop mid-computation");
      applyStimulus(700, 1'b0, 0);
      sc0 = strobeCount;
      @(negedge clock);
      bus.signal_in = 16'(900);
      bus.strobe_in = 1'b1;
      modelShift(900);
      phase = 0;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      @(negedge clock);
      bus.enable = 1'b0;
      @(negedge clock);
      bus.signal_in = 16'(30000);
      bus.strobe_in = 1'b1;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      repeat (2) @(negedge clock);
      bus.enable = 1'b1;
      repeat (8) @(negedge clock);
      checkOutput("abort_no_strobe", strobeCount - sc0, 0);
      applyStimulus(1100, 1'b0, 0);
      repeat (2) @(negedge clock);
      checkOutput("reenable_first_silent", strobeCount - sc0, 0);
      applyStimulus(1300, 1'b0, 0);
      repeat (2) @(negedge clock);
      checkOutput("reenable_second_out", strobeCount - sc0, 1);

      $display("[TB] reset mid-PAIR2");
      applyStimulus(2000, 1'b0, 0);
      sc0 = strobeCount;
      @(negedge clock);
      bus.signal_in = 16'(3000);
      bus.strobe_in = 1'b1;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #2;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      modelClear();
      checkOutput("midrst_overrun", bus.overrun, 0);
      checkOutput("midrst_signal_out", longint'(bus.signal_out), 0);
      repeat (8) @(negedge clock);
      checkOutput("midrst_no_strobe", strobeCount - sc0, 0);

      bus.enable = 1'b0;
      @(negedge clock);
      bus.signal_in = 16'(20000);
      bus.strobe_in = 1'b1;
      @(negedge clock);
      bus.strobe_in = 1'b0;
      @(negedge clock);
      checkOutput("disabled_no_overrun", bus.overrun, 0);
      bus.enable = 1'b1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b1, 0);
      end

      repeat (10) @(negedge clock);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
